// File: rtl/mem_rd_req_gen_pkg.sv
// Shared definitions for the memory read-request generator: default widths,
// descriptor field layout and the walker state encoding.
package mem_rd_req_gen_pkg;

    localparam int DEF_ADDR_W        = 32;
    localparam int DEF_BASE_ADDR_W   = DEF_ADDR_W;
    localparam int DEF_OFFSET_ADDR_W = DEF_ADDR_W;
    localparam int DEF_TX_SIZE_WIDTH = 20;
    localparam int DEF_RD_LOOP_W     = 10;
    localparam int DEF_D_TYPE_W      = 2;
    localparam int DEF_ROM_ADDR_W    = 4;

    localparam int ROM_WIDTH = DEF_BASE_ADDR_W + DEF_OFFSET_ADDR_W + DEF_TX_SIZE_WIDTH
                             + DEF_RD_LOOP_W + DEF_D_TYPE_W;

    // Descriptor is packed MSB-first as {type, base, offset, size, loop_max}
    localparam int LOOP_LSB = 0;
    localparam int SIZE_LSB = LOOP_LSB + DEF_RD_LOOP_W;
    localparam int OFF_LSB  = SIZE_LSB + DEF_TX_SIZE_WIDTH;
    localparam int BASE_LSB = OFF_LSB + DEF_OFFSET_ADDR_W;
    localparam int TYPE_LSB = BASE_LSB + DEF_BASE_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_rd_cfg_rom.sv
// Descriptor store: one write port, one read port with a registered output.
// Array contents are deliberately left unreset; only the read register clears.
module mem_rd_cfg_rom #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 96
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [1<<ADDR_W];
    logic [DATA_W-1:0] r_rdData;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdData <= '0;
        end else if (i_rd_en) begin
            r_rdData <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rdData;

endmodule

// File: rtl/mem_rd_req_gen.sv
// Walks the descriptor ROM and issues loop_max+1 strided read requests per
// descriptor on the rd_req/rd_addr/rd_req_size interface.
module mem_rd_req_gen
    import mem_rd_req_gen_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int BASE_ADDR_W   = ADDR_W,
    parameter int OFFSET_ADDR_W = ADDR_W,
    parameter int TX_SIZE_WIDTH = DEF_TX_SIZE_WIDTH,
    parameter int RD_LOOP_W     = DEF_RD_LOOP_W,
    parameter int D_TYPE_W      = DEF_D_TYPE_W,
    parameter int ROM_ADDR_W    = DEF_ROM_ADDR_W,
    localparam int ROM_W        = BASE_ADDR_W + OFFSET_ADDR_W + TX_SIZE_WIDTH + RD_LOOP_W + D_TYPE_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    output logic                     o_done,
    output logic                     o_busy,
    input  logic                     i_cfg_wr_en,
    input  logic [ROM_ADDR_W-1:0]    i_cfg_wr_addr,
    input  logic [ROM_W-1:0]         i_cfg_wr_data,
    input  logic [ROM_ADDR_W:0]      i_cfg_num_entries,
    input  logic                     i_rd_ready,
    output logic                     o_rd_req,
    output logic [ADDR_W-1:0]        o_rd_addr,
    output logic [TX_SIZE_WIDTH-1:0] o_rd_req_size,
    output logic [D_TYPE_W-1:0]      o_rd_type
);

    localparam int SZ_LSB = RD_LOOP_W;
    localparam int OF_LSB = SZ_LSB + TX_SIZE_WIDTH;
    localparam int BA_LSB = OF_LSB + OFFSET_ADDR_W;
    localparam int TY_LSB = BA_LSB + BASE_ADDR_W;
    localparam logic [ROM_ADDR_W:0] MAX_ENTRIES = (ROM_ADDR_W+1)'(1 << ROM_ADDR_W);

    state_t                   r_state;
    logic [ROM_ADDR_W:0]      r_idx;
    logic [ROM_ADDR_W:0]      r_numEntries;
    logic [RD_LOOP_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]        r_acc;

    logic [ROM_W-1:0]         w_romData;
    logic [RD_LOOP_W-1:0]     w_loopMax;
    logic [TX_SIZE_WIDTH-1:0] w_size;
    logic [OFFSET_ADDR_W-1:0] w_offset;
    logic [BASE_ADDR_W-1:0]   w_base;
    logic [D_TYPE_W-1:0]      w_type;
    logic                     w_issue;
    logic                     w_handshake;
    logic [ROM_ADDR_W:0]      w_numClamped;
    logic [ROM_ADDR_W:0]      w_nextIdx;

    // The ROM read register is only loaded in LOAD, so it holds the current
    // descriptor stable for the whole ISSUE phase.
    mem_rd_cfg_rom #(
        .ADDR_W (ROM_ADDR_W),
        .DATA_W (ROM_W)
    ) u_rom (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_cfg_wr_en && (r_state == IDLE)),
        .i_wr_addr (i_cfg_wr_addr),
        .i_wr_data (i_cfg_wr_data),
        .i_rd_en   (r_state == LOAD),
        .i_rd_addr (r_idx[ROM_ADDR_W-1:0]),
        .o_rd_data (w_romData)
    );

    assign w_loopMax = w_romData[SZ_LSB-1:0];
    assign w_size    = w_romData[OF_LSB-1:SZ_LSB];
    assign w_offset  = w_romData[BA_LSB-1:OF_LSB];
    assign w_base    = w_romData[TY_LSB-1:BA_LSB];
    assign w_type    = w_romData[ROM_W-1:TY_LSB];

    assign w_issue      = (r_state == ISSUE);
    assign w_handshake  = w_issue && i_rd_ready;
    assign w_numClamped = (i_cfg_num_entries > MAX_ENTRIES) ? MAX_ENTRIES : i_cfg_num_entries;
    assign w_nextIdx    = r_idx + 1'b1;

    assign o_rd_req      = w_handshake;
    assign o_rd_addr     = w_issue ? (ADDR_W'(w_base) + r_acc) : '0;
    assign o_rd_req_size = w_issue ? w_size : '0;
    assign o_rd_type     = w_issue ? w_type : '0;
    assign o_done        = (r_state == DONE);
    assign o_busy        = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_numEntries <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_numEntries <= w_numClamped;
                        r_idx        <= '0;
                        r_cnt        <= '0;
                        r_acc        <= '0;
                        r_state      <= (w_numClamped == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (w_handshake) begin
                        if (r_cnt == w_loopMax) begin
                            r_cnt   <= '0;
                            r_acc   <= '0;
                            r_idx   <= w_nextIdx;
                            r_state <= (w_nextIdx == r_numEntries) ? DONE : LOAD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_acc <= r_acc + ADDR_W'(w_offset);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rd_req_gen.sv
// Self-checking bench: directed scenarios plus randomized descriptor walks,
// compared cycle by cycle against a request-list model built from the descriptors.
module tb_mem_rd_req_gen;
    import mem_rd_req_gen_pkg::*;

    localparam int DEPTH = 1 << DEF_ROM_ADDR_W;

    logic                         clk;
    logic                         rst_n;
    logic                         start;
    logic                         done;
    logic                         busy;
    logic                         cfgWrEn;
    logic [DEF_ROM_ADDR_W-1:0]    cfgWrAddr;
    logic [ROM_WIDTH-1:0]         cfgWrData;
    logic [DEF_ROM_ADDR_W:0]      cfgNumEntries;
    logic                         rdReady;
    logic                         rdReq;
    logic [DEF_ADDR_W-1:0]        rdAddr;
    logic [DEF_TX_SIZE_WIDTH-1:0] rdReqSize;
    logic [DEF_D_TYPE_W-1:0]      rdType;

    typedef struct {
        logic [DEF_ADDR_W-1:0]        addr;
        logic [DEF_TX_SIZE_WIDTH-1:0] size;
        logic [DEF_D_TYPE_W-1:0]      typ;
        bit                           last;
    } req_t;

    req_t                         expQ[$];
    logic [DEF_ADDR_W-1:0]        mBase [DEPTH];
    logic [DEF_ADDR_W-1:0]        mOff  [DEPTH];
    logic [DEF_TX_SIZE_WIDTH-1:0] mSize [DEPTH];
    logic [DEF_RD_LOOP_W-1:0]     mLoop [DEPTH];
    logic [DEF_D_TYPE_W-1:0]      mType [DEPTH];

    int checks = 0;
    int errors = 0;

    mem_rd_req_gen dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .o_done            (done),
        .o_busy            (busy),
        .i_cfg_wr_en       (cfgWrEn),
        .i_cfg_wr_addr     (cfgWrAddr),
        .i_cfg_wr_data     (cfgWrData),
        .i_cfg_num_entries (cfgNumEntries),
        .i_rd_ready        (rdReady),
        .o_rd_req          (rdReq),
        .o_rd_addr         (rdAddr),
        .o_rd_req_size     (rdReqSize),
        .o_rd_type         (rdType)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Writes one descriptor into the DUT ROM and the bench's own copy; called in IDLE.
    task automatic applyStimulus(input int idx, input logic [DEF_D_TYPE_W-1:0] typ,
                                 input logic [DEF_ADDR_W-1:0] base, input logic [DEF_ADDR_W-1:0] off,
                                 input logic [DEF_TX_SIZE_WIDTH-1:0] size, input logic [DEF_RD_LOOP_W-1:0] loopMax);
        mBase[idx] = base;
        mOff[idx]  = off;
        mSize[idx] = size;
        mLoop[idx] = loopMax;
        mType[idx] = typ;
        cfgWrEn    = 1'b1;
        cfgWrAddr  = DEF_ROM_ADDR_W'(idx);
        cfgWrData  = {typ, base, off, size, loopMax};
        @(posedge clk);
        #1;
        cfgWrEn = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low in the 2nd/3rd issue cycles
    task automatic runWalk(input int n, input int mode);
        int   nc;
        req_t item;
        bit   bubble, doneDue, finished, exitOk, expReq;
        nc = (n > DEPTH) ? DEPTH : n;
        expQ.delete();
        for (int e = 0; e < nc; e++) begin
            for (int j = 0; j <= int'(mLoop[e]); j++) begin
                item.addr = mBase[e] + DEF_ADDR_W'(j) * mOff[e];
                item.size = mSize[e];
                item.typ  = mType[e];
                item.last = (j == int'(mLoop[e]));
                expQ.push_back(item);
            end
        end
        start         = 1'b1;
        cfgNumEntries = (DEF_ROM_ADDR_W+1)'(n);
        rdReady       = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        bubble   = (nc != 0);
        doneDue  = (nc == 0);
        finished = 1'b0;
        exitOk   = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            case (mode)
                0:       rdReady = 1'b1;
                1:       rdReady = ($urandom_range(0, 3) != 0);
                default: rdReady = !(k == 3 || k == 4);
            endcase
            start         = (k == 1);
            cfgWrEn       = (k == 1);
            cfgWrAddr     = '0;
            cfgWrData     = {$urandom, $urandom, $urandom};
            cfgNumEntries = (DEF_ROM_ADDR_W+1)'($urandom_range(0, 31));
            @(negedge clk);
            if (finished) begin
                checkOutput("idle_done", 64'(done), 64'(0));
                checkOutput("idle_busy", 64'(busy), 64'(0));
                checkOutput("idle_req", 64'(rdReq), 64'(0));
                exitOk = 1'b1;
                break;
            end
            expReq = !doneDue && !bubble && (expQ.size() != 0) && rdReady;
            checkOutput("rd_req", 64'(rdReq), 64'(expReq));
            checkOutput("done", 64'(done), 64'(doneDue));
            checkOutput("busy", 64'(busy), 64'(1));
            if (doneDue) begin
                finished = 1'b1;
            end else if (bubble) begin
                bubble = 1'b0;
            end else if (expReq) begin
                item = expQ.pop_front();
                checkOutput("rd_addr", 64'(rdAddr), 64'(item.addr));
                checkOutput("rd_size", 64'(rdReqSize), 64'(item.size));
                checkOutput("rd_type", 64'(rdType), 64'(item.typ));
                if (expQ.size() == 0) doneDue = 1'b1;
                else if (item.last) bubble = 1'b1;
            end else if (expQ.size() != 0) begin
                checkOutput("hold_addr", 64'(rdAddr), 64'(expQ[0].addr));
                checkOutput("hold_size", 64'(rdReqSize), 64'(expQ[0].size));
            end
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        cfgWrEn = 1'b0;
        if (!exitOk) checkOutput("walk_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic resetMidWalk();
        start         = 1'b1;
        cfgNumEntries = 1;
        rdReady       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("pre_rst_req", 64'(rdReq), 64'(1));
        checkOutput("pre_rst_addr", 64'(rdAddr), 64'(32'h1040));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req", 64'(rdReq), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_addr", 64'(rdAddr), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_done", 64'(done), 64'(0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        cfgWrEn       = 1'b0;
        cfgWrAddr     = '0;
        cfgWrData     = '0;
        cfgNumEntries = '0;
        rdReady       = 1'b1;
        #2;
        checkOutput("reset_req", 64'(rdReq), 64'(0));
        checkOutput("reset_addr", 64'(rdAddr), 64'(0));
        checkOutput("reset_size", 64'(rdReqSize), 64'(0));
        checkOutput("reset_type", 64'(rdType), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(0, 2'd1, 32'h1000, 32'h40, 20'd16, 10'd3);
        runWalk(1, 0);
        applyStimulus(1, 2'd2, 32'h8000, 32'h10, 20'd8, 10'd0);
        runWalk(2, 0);
        runWalk(1, 2);
        runWalk(0, 0);

        applyStimulus(0, 2'd3, 32'hFFFF_FFF0, 32'h10, 20'd5, 10'd1);
        runWalk(1, 0);
        applyStimulus(0, 2'd1, 32'h1000, 32'h40, 20'd16, 10'd3);

        resetMidWalk();
        runWalk(1, 0);

        for (int iter = 0; iter < 6; iter++) begin
            for (int e = 0; e < DEPTH; e++) begin
                applyStimulus(e, DEF_D_TYPE_W'($urandom_range(0, 3)), $urandom, $urandom,
                              DEF_TX_SIZE_WIDTH'($urandom), DEF_RD_LOOP_W'($urandom_range(0, 3)));
            end
            runWalk((iter == 0) ? 20 : int'($urandom_range(1, 16)), 1);
        end
        runWalk(0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
